// File: rtl/exp_2_block_16.sv
// Softmax exp stage: computes 2^(x*log2(e)) for non-positive Q5.10 inputs as unsigned Q0.16
// through a 3-stage pipeline, with a frame controller counting number_of_data words per frame.
module exp_2_block_16 #(
  parameter int data_size      = 16,
  parameter int number_of_data = 10
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic [data_size-1:0] exp_2_data_i,
  input  logic                 exp_2_data_valid_i,
  output logic [data_size-1:0] exp_2_data_o,
  output logic                 exp_2_data_valid_o,
  output logic [7:0]           exp_2_count_o,
  output logic                 exp_2_done_o
);

  localparam logic [7:0]  N         = 8'(number_of_data);
  localparam logic [31:0] LOG2E_Q15 = 32'd47274;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // round(65536 * 2^(-n/16)); entries 0 and 16 bracket one octave.
  function automatic logic [16:0] exp2_lut(input logic [4:0] n);
    case (n)
      5'd0:    exp2_lut = 17'd65536;
      5'd1:    exp2_lut = 17'd62757;
      5'd2:    exp2_lut = 17'd60097;
      5'd3:    exp2_lut = 17'd57549;
      5'd4:    exp2_lut = 17'd55109;
      5'd5:    exp2_lut = 17'd52773;
      5'd6:    exp2_lut = 17'd50535;
      5'd7:    exp2_lut = 17'd48393;
      5'd8:    exp2_lut = 17'd46341;
      5'd9:    exp2_lut = 17'd44376;
      5'd10:   exp2_lut = 17'd42495;
      5'd11:   exp2_lut = 17'd40693;
      5'd12:   exp2_lut = 17'd38968;
      5'd13:   exp2_lut = 17'd37316;
      5'd14:   exp2_lut = 17'd35734;
      5'd15:   exp2_lut = 17'd34219;
      default: exp2_lut = 17'd32768;
    endcase
  endfunction

  state_e                 state_q, state_d;
  logic [7:0]             acc_cnt_q, acc_cnt_d;
  logic [7:0]             out_cnt_q, out_cnt_d;
  logic                   s1_valid_q, s2_valid_q, valid_o_q;
  logic [21:0]            s1_k_q, s1_k_d, s2_k_q;
  logic [9:0]             s1_f_q, s1_f_d;
  logic [16:0]            s2_r_q, s2_r_d;
  logic [data_size-1:0]   data_o_q, data_o_d;
  logic                   accept;

  assign accept = exp_2_data_valid_i && (state_q == IDLE || state_q == RUN) && (acc_cnt_q < N);

  // Stage 1: clamp positives to zero, convert to a base-2 exponent split into k.f
  logic [data_size-1:0] neg_x;
  logic [15:0]          m;
  logic [31:0]          t;
  always_comb begin
    neg_x  = -exp_2_data_i;
    m      = exp_2_data_i[data_size-1] ? neg_x[15:0] : 16'd0;
    t      = ({16'd0, m} * LOG2E_Q15) >> 15;
    s1_k_d = t[31:10];
    s1_f_d = t[9:0];
  end

  // Stage 2: linear interpolation between adjacent LUT entries
  logic [16:0] lut_lo, lut_hi, lut_diff;
  logic [22:0] interp;
  always_comb begin
    lut_lo   = exp2_lut({1'b0, s1_f_q[9:6]});
    lut_hi   = exp2_lut({1'b0, s1_f_q[9:6]} + 5'd1);
    lut_diff = lut_lo - lut_hi;
    interp   = {6'd0, lut_diff} * {17'd0, s1_f_q[5:0]};
    s2_r_d   = lut_lo - 17'(interp >> 6);
  end

  // Stage 3: apply the integer shift and saturate 1.0 to the largest Q0.16 code
  logic [16:0] y;
  always_comb begin
    y        = (s2_k_q >= 22'd17) ? 17'd0 : (s2_r_q >> s2_k_q[4:0]);
    data_o_d = '0;
    if (s2_valid_q) data_o_d = data_size'(y[16] ? 16'hFFFF : y[15:0]);
  end

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    out_cnt_d = out_cnt_q;
    if (s2_valid_q && out_cnt_q < N) out_cnt_d = out_cnt_q + 8'd1;
    unique case (state_q)
      IDLE: if (accept) begin
        acc_cnt_d = 8'd1;
        state_d   = (N == 8'd1) ? DRAIN : RUN;
      end
      RUN: if (accept) begin
        acc_cnt_d = acc_cnt_q + 8'd1;
        if (acc_cnt_q + 8'd1 == N) state_d = DRAIN;
      end
      DRAIN: if (valid_o_q && out_cnt_q == N) state_d = DONE;
      DONE: begin
        acc_cnt_d = '0;
        out_cnt_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with the valids so a mid-frame reset
  // leaves nothing stale and the output word reads 0 straight away.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      acc_cnt_q  <= '0;
      out_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      valid_o_q  <= 1'b0;
      s1_k_q     <= '0;
      s1_f_q     <= '0;
      s2_k_q     <= '0;
      s2_r_q     <= '0;
      data_o_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
      state_q    <= state_d;
      acc_cnt_q  <= acc_cnt_d;
      out_cnt_q  <= out_cnt_d;
      s1_valid_q <= accept;
      s2_valid_q <= s1_valid_q;
      valid_o_q  <= s2_valid_q;
      s1_k_q     <= s1_k_d;
      s1_f_q     <= s1_f_d;
      s2_k_q     <= s1_k_q;
      s2_r_q     <= s2_r_d;
      data_o_q   <= data_o_d;
    end
  end

  assign exp_2_data_o       = data_o_q;
  assign exp_2_data_valid_o = valid_o_q;
  assign exp_2_count_o      = out_cnt_q;
  assign exp_2_done_o       = (state_q == DONE);

endmodule
